// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch sequencer with 2-entry {pc, instruction} queue.
// Optional FETCH_STATS_EN adds fetch_count, a saturating count of instructions accepted by decode.
module instr_fetch #(
  parameter int AW       = 8,
  parameter int IW       = 32,
  parameter int PC_STEP  = 1,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [IW-1:0] inst_data,
`ifdef FETCH_STATS_EN
  output logic [15:0]   fetch_count,
`endif
  output logic [AW-1:0] inst_pc
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] pc0, pc1;
  logic [IW-1:0] data0, data1;
  logic [1:0]    count;
  logic          squash;

  logic          pop, ack, push;
  logic [1:0]    count_n;
  logic [AW-1:0] fetch_pc_n;

  assign mem_req    = (state == S_WAIT);
  assign mem_addr   = addr_q;
  assign inst_valid = (count != 2'd0);
  assign inst_data  = data0;
  assign inst_pc    = pc0;

  assign pop  = inst_valid && inst_ready;
  assign ack  = (state == S_WAIT) && mem_ack;
  assign push = ack && !squash && !redirect;

  always_comb begin
    count_n    = count + {1'b0, push} - {1'b0, pop};
    fetch_pc_n = fetch_pc;
    if (redirect) begin
      count_n    = 2'd0;
      fetch_pc_n = redirect_addr;
    end else if (push) begin
      fetch_pc_n = fetch_pc + AW'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      fetch_pc <= AW'(RESET_PC);
      addr_q   <= AW'(RESET_PC);
      count    <= 2'd0;
      squash   <= 1'b0;
      pc0      <= '0;
      pc1      <= '0;
      data0    <= '0;
      data1    <= '0;
    end else begin
      count    <= count_n;
      fetch_pc <= fetch_pc_n;

      if (redirect) begin
        state  <= S_WAIT;
        // an un-acked request cannot be withdrawn, so its response must be discarded later
        squash <= (state == S_WAIT) && !mem_ack;
      end else if (state == S_IDLE || ack) begin
        state <= (count_n < 2'd2) ? S_WAIT : S_IDLE;
        if (ack) squash <= 1'b0;
      end

      // hold the address of a pending request until it is acknowledged
      if (!(state == S_WAIT && !mem_ack)) addr_q <= fetch_pc_n;

      if (!redirect) begin
        unique case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              pc0   <= addr_q;
              data0 <= mem_rdata;
            end else begin
              pc1   <= addr_q;
              data1 <= mem_rdata;
            end
          end
          2'b01: begin
            pc0   <= pc1;
            data0 <= data1;
          end
          2'b11: begin
            // a request only issues with a free slot, so count is 1 here
            pc0   <= addr_q;
            data0 <= mem_rdata;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= 16'd0;
    end else if (pop && fetch_count != 16'hFFFF) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end
`endif

endmodule
